// File: rtl/trace_line_streamer.sv
// Serialises a captured snapshot of labelled data words into one ASCII line,
// one byte per valid/ready handshake: "LB:HHHH LB:HHHH ...\r\n".
module trace_line_streamer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_FIELDS = 4,
    parameter bit          UPPERCASE  = 1'b1,
    parameter bit          EOL_EN     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [16*NUM_FIELDS-1:0]     labels,
    input  logic [DATA_W*NUM_FIELDS-1:0] fields,
    output logic                         busy,
    output logic [7:0]                   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         done
);

    localparam int unsigned DIGITS = DATA_W / 4;
    localparam int unsigned FW     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int unsigned DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [FW-1:0] LastField = FW'(NUM_FIELDS - 1);
    localparam logic [DW-1:0] LastDigit = DW'(DIGITS - 1);

    typedef enum logic [2:0] {
        StIdle, StLabHi, StLabLo, StColon, StDigit, StSep, StCr, StLf
    } state_e;

    state_e                        state_q, state_d;
    logic [FW-1:0]                 field_q, field_d;
    logic [DW-1:0]                 digit_q, digit_d;
    logic                          done_q, done_d;
    logic [16*NUM_FIELDS-1:0]      labels_q;
    logic [DATA_W*NUM_FIELDS-1:0]  fields_q;

    logic [15:0]       cur_label;
    logic [DATA_W-1:0] cur_word;
    logic [3:0]        nibble;
    logic [7:0]        hex_char;

    // Current field/nibble selection from the captured snapshot
    always_comb begin
        cur_label = '0;
        cur_word  = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (field_q == FW'(i)) begin
                cur_label = labels_q[16*i +: 16];
                cur_word  = fields_q[DATA_W*i +: DATA_W];
            end
        end
        nibble = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (digit_q == DW'(d)) begin
                nibble = cur_word[4*d +: 4];
            end
        end
        if (nibble < 4'd10) begin
            hex_char = 8'h30 + {4'h0, nibble};
        end else begin
            hex_char = (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nibble};
        end
    end

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        digit_d   = digit_q;
        done_d    = 1'b0;
        out_valid = 1'b1;
        out_data  = 8'h00;
        unique case (state_q)
            StIdle: begin
                out_valid = 1'b0;
                if (start) begin
                    state_d = StLabHi;
                    field_d = '0;
                end
            end
            StLabHi: begin
                out_data = cur_label[15:8];
                if (out_ready) state_d = StLabLo;
            end
            StLabLo: begin
                out_data = cur_label[7:0];
                if (out_ready) state_d = StColon;
            end
            StColon: begin
                out_data = 8'h3A;
                if (out_ready) begin
                    state_d = StDigit;
                    digit_d = LastDigit;
                end
            end
            StDigit: begin
                out_data = hex_char;
                if (out_ready) begin
                    if (digit_q != '0) begin
                        digit_d = digit_q - 1'b1;
                    end else if (field_q != LastField) begin
                        state_d = StSep;
                    end else if (EOL_EN) begin
                        state_d = StCr;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StSep: begin
                out_data = 8'h20;
                if (out_ready) begin
                    state_d = StLabHi;
                    field_d = field_q + 1'b1;
                end
            end
            StCr: begin
                out_data = 8'h0D;
                if (out_ready) state_d = StLf;
            end
            StLf: begin
                out_data = 8'h0A;
                if (out_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                out_valid = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            field_q  <= '0;
            digit_q  <= '0;
            done_q   <= 1'b0;
            labels_q <= '0;
            fields_q <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            digit_q <= digit_d;
            done_q  <= done_d;
            // Snapshot only on acceptance so later input changes cannot leak into the line
            if (state_q == StIdle && start) begin
                labels_q <= labels;
                fields_q <= fields;
            end
        end
    end

endmodule
